// File: rtl/sram_responder.sv
// sram_responder: behavioural model of an asynchronous-style SRAM seen from a
// synchronous controller. Writes are held until WE_N/CE_N release and then
// committed; reads drive SRAM_DQ after READ_LAT stable-address cycles.
// Optional feature macro: SRAM_RESP_BYTE_LANE_EN (honour UB_N/LB_N byte lanes).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | chip deselected or no access in progress
// RD_WAIT   | read address latched, counting stable-address cycles
// RD_DRIVE  | read data for the latched address is on SRAM_DQ
// WR_ACTIVE | write strobe low, address/data captured every cycle
module sram_responder #(
    parameter int ADDR_W   = 17,
    parameter int DATA_W   = 16,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    input  logic              SRAM_WE_N,
    input  logic              SRAM_OE_N,
    input  logic              SRAM_CE_N,
    input  logic              SRAM_UB_N,
    input  logic              SRAM_LB_N,
    output logic [15:0]       wr_count,
    output logic [15:0]       rd_count,
    output logic              dq_drive,
    output logic              collision
);

    localparam int HALF = DATA_W / 2;
    localparam logic [3:0] LAT_C = 4'(READ_LAT);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] RD_WAIT   = 2'd1;
    localparam logic [1:0] RD_DRIVE  = 2'd2;
    localparam logic [1:0] WR_ACTIVE = 2'd3;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    logic [1:0]        state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic [ADDR_W-1:0] rd_addr, rd_addr_nx;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              capture, commit, rd_done;
    logic              dq_drive_q;
    logic              drive_en, lo_en, hi_en;
    logic [DATA_W-1:0] rd_word;

`ifdef SRAM_RESP_BYTE_LANE_EN
    logic              wr_ub_n, wr_lb_n;
`else
    logic              unused_lanes;
    assign unused_lanes = SRAM_UB_N ^ SRAM_LB_N;
`endif

    // Next-state, read-latency counter and write capture/commit decisions
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        rd_addr_nx = rd_addr;
        capture    = 1'b0;
        commit     = 1'b0;
        rd_done    = 1'b0;
        case (state)
            IDLE: begin
                if (!SRAM_CE_N && !SRAM_WE_N) begin
                    state_nx = WR_ACTIVE;
                    capture  = 1'b1;
                end else if (!SRAM_CE_N && !SRAM_OE_N) begin
                    state_nx   = RD_WAIT;
                    cnt_nx     = 4'd1;
                    rd_addr_nx = SRAM_ADDR;
                end
            end
            RD_WAIT, RD_DRIVE: begin
                if (SRAM_CE_N || (SRAM_OE_N && SRAM_WE_N)) begin
                    state_nx = IDLE;
                    cnt_nx   = 4'd0;
                    rd_done  = (state == RD_DRIVE);
                end else if (!SRAM_WE_N) begin
                    // Write takes over the bus; the interrupted read is not counted
                    state_nx = WR_ACTIVE;
                    cnt_nx   = 4'd0;
                    capture  = 1'b1;
                end else if (SRAM_ADDR != rd_addr) begin
                    state_nx   = RD_WAIT;
                    cnt_nx     = 4'd1;
                    rd_addr_nx = SRAM_ADDR;
                    rd_done    = (state == RD_DRIVE);
                end else if (state == RD_WAIT) begin
                    if (cnt + 4'd1 >= LAT_C) begin
                        state_nx = RD_DRIVE;
                        cnt_nx   = LAT_C;
                    end else begin
                        cnt_nx = cnt + 4'd1;
                    end
                end
            end
            WR_ACTIVE: begin
                if (SRAM_WE_N || SRAM_CE_N) begin
                    state_nx = IDLE;
                    commit   = 1'b1;
                end else begin
                    capture = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // FSM state, read counter and latched read address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            rd_addr <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            rd_addr <= rd_addr_nx;
        end
    end

    // Write holding registers, refreshed every cycle the write strobe is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr <= '0;
            wr_data <= '0;
`ifdef SRAM_RESP_BYTE_LANE_EN
            wr_ub_n <= 1'b1;
            wr_lb_n <= 1'b1;
`endif
        end else if (capture) begin
            wr_addr <= SRAM_ADDR;
            wr_data <= SRAM_DQ;
`ifdef SRAM_RESP_BYTE_LANE_EN
            wr_ub_n <= SRAM_UB_N;
            wr_lb_n <= SRAM_LB_N;
`endif
        end
    end

    // Memory array commit; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (commit) begin
`ifdef SRAM_RESP_BYTE_LANE_EN
            if (!wr_lb_n) mem[wr_addr][HALF-1:0]      <= wr_data[HALF-1:0];
            if (!wr_ub_n) mem[wr_addr][DATA_W-1:HALF] <= wr_data[DATA_W-1:HALF];
`else
            mem[wr_addr] <= wr_data;
`endif
        end
    end

    // Access counters; both wrap naturally at 16 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_count <= 16'd0;
            rd_count <= 16'd0;
        end else begin
            if (commit)  wr_count <= wr_count + 16'd1;
            if (rd_done) rd_count <= rd_count + 16'd1;
        end
    end

    // Sticky contention flag: controller pulled WE_N while we drove last cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dq_drive_q <= 1'b0;
            collision  <= 1'b0;
        end else begin
            dq_drive_q <= dq_drive;
            if (!SRAM_WE_N && dq_drive_q) collision <= 1'b1;
        end
    end

    // Drive only while strobes still request a read of the latched address,
    // so an address change floats the bus in the very cycle it happens
    assign rd_word  = mem[rd_addr];
    assign drive_en = (state == RD_DRIVE) && !SRAM_CE_N && !SRAM_OE_N &&
                      SRAM_WE_N && (SRAM_ADDR == rd_addr);
`ifdef SRAM_RESP_BYTE_LANE_EN
    assign lo_en = drive_en && !SRAM_LB_N;
    assign hi_en = drive_en && !SRAM_UB_N;
`else
    assign lo_en = drive_en;
    assign hi_en = drive_en;
`endif
    assign dq_drive = lo_en || hi_en;

    assign SRAM_DQ[HALF-1:0]      = lo_en ? rd_word[HALF-1:0]      : {HALF{1'bz}};
    assign SRAM_DQ[DATA_W-1:HALF] = hi_en ? rd_word[DATA_W-1:HALF] : {(DATA_W-HALF){1'bz}};

endmodule
